mem_cmd_responder: RTL and testbench

MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

---
 rtl/mem_responder_pkg.sv | 39 +++
 rtl/bsg_mem_1rw_sync_mask_write_byte.sv | 29 ++
 rtl/mem_cmd_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_cmd_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory command responder: message type and size
// encodings, FSM states and the registered command header.
package mem_responder_pkg;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } mem_msg_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1B  = 3'd0,
    e_mem_size_2B  = 3'd1,
    e_mem_size_4B  = 3'd2,
    e_mem_size_8B  = 3'd3,
    e_mem_size_16B = 3'd4,
    e_mem_size_32B = 3'd5,
    e_mem_size_64B = 3'd6
  } mem_size_e;

  typedef enum logic [1:0] {
    e_idle,
    e_wait,
    e_resp
  } mem_state_e;

  // Header fields are sized for the widest supported address/payload so the
  // struct can stay unparameterized; the top uses the low bits it needs.
  localparam int hdr_field_max_gp = 64;

  typedef struct packed {
    logic [hdr_field_max_gp-1:0] payload;
    logic [2:0]                  size;
    logic [hdr_field_max_gp-1:0] addr;
    logic [3:0]                  msg_type;
  } mem_header_s;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous block storage with per-byte write enables.
// Contents are deliberately not reset.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter  int els_p               = 1024,
  parameter  int data_width_p        = 512,
  localparam int addr_width_lp       = $clog2(els_p),
  localparam int write_mask_width_lp = data_width_p / 8
) (
  input  logic                           clk_i,
  input  logic                           v_i,
  input  logic                           w_i,
  input  logic [addr_width_lp-1:0]       addr_i,
  input  logic [data_width_p-1:0]        data_i,
  input  logic [write_mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]        data_o
);

  logic [data_width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < write_mask_width_lp; i++) begin
        if (write_mask_i[i]) mem_r[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end
    end
    if (v_i & ~w_i) data_o <= mem_r[addr_i];
  end

endmodule

// File: rtl/mem_cmd_responder.sv
// Fixed-latency memory command responder: one command in flight, cached and
// uncached reads/writes against block storage, response held until yumi.
module mem_cmd_responder
  import mem_responder_pkg::*;
#(
  parameter  int paddr_width_p   = 40,
  parameter  int block_width_p   = 512,
  parameter  int payload_width_p = 16,
  parameter  int mem_els_p       = 1024,
  parameter  int latency_p       = 4,
  localparam int msg_width_lp    = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [msg_width_lp-1:0] mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [msg_width_lp-1:0] mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i
);

  localparam int         block_bytes_lp  = block_width_p / 8;
  localparam int         offset_width_lp = $clog2(block_bytes_lp);
  localparam int         index_width_lp  = $clog2(mem_els_p);
  localparam logic [2:0] max_size_lp     = 3'(offset_width_lp);
  localparam int         size_lsb_lp     = 4 + paddr_width_p;
  localparam int         payload_lsb_lp  = size_lsb_lp + 3;
  localparam int         data_lsb_lp     = payload_lsb_lp + payload_width_p;

  function automatic logic [2:0] clamp_size(input logic [2:0] sz);
    return (sz > max_size_lp) ? max_size_lp : sz;
  endfunction

  function automatic logic [offset_width_lp-1:0] align_offset(
    input logic [offset_width_lp-1:0] off, input logic [2:0] sz);
    logic [offset_width_lp-1:0] low;
    low = offset_width_lp'((32'd1 << sz) - 32'd1);
    return off & ~low;
  endfunction

  function automatic logic [block_bytes_lp-1:0] size_mask(input logic [2:0] sz);
    logic [block_bytes_lp-1:0] m;
    for (int i = 0; i < block_bytes_lp; i++) m[i] = (i < (1 << sz));
    return m;
  endfunction

  function automatic logic [block_width_p-1:0] uc_extract(
    input logic [block_width_p-1:0] blk, input logic [offset_width_lp-1:0] off,
    input logic [2:0] sz);
    logic [block_width_p-1:0]  shifted;
    logic [block_bytes_lp-1:0] keep;
    shifted = blk >> {off, 3'b000};
    keep    = size_mask(sz);
    for (int i = 0; i < block_bytes_lp; i++) begin
      if (!keep[i]) shifted[i*8 +: 8] = 8'h00;
    end
    return shifted;
  endfunction

  logic [3:0]                 cmd_type;
  logic [paddr_width_p-1:0]   cmd_addr;
  logic [2:0]                 cmd_size;
  logic [payload_width_p-1:0] cmd_payload;
  logic [block_width_p-1:0]   cmd_data;
  logic                       accept;
  logic                       cmd_is_wr, cmd_is_uc_wr;
  logic [2:0]                 cmd_size_c;
  logic [offset_width_lp-1:0] cmd_off;
  logic [index_width_lp-1:0]  mem_index;
  logic [block_bytes_lp-1:0]  mem_wmask;
  logic [block_width_p-1:0]   mem_wdata, mem_rdata;

  mem_state_e  state_r, state_n;
  logic [7:0]  cnt_r, cnt_n;
  mem_header_s hdr_r;
  logic        ready_en_r;
  logic        vld_p0;

  assign cmd_type    = mem_cmd_i[3:0];
  assign cmd_addr    = mem_cmd_i[4 +: paddr_width_p];
  assign cmd_size    = mem_cmd_i[size_lsb_lp +: 3];
  assign cmd_payload = mem_cmd_i[payload_lsb_lp +: payload_width_p];
  assign cmd_data    = mem_cmd_i[data_lsb_lp +: block_width_p];

  assign accept       = mem_cmd_v_i & mem_cmd_ready_o;
  assign cmd_is_wr    = (cmd_type == e_mem_msg_wr);
  assign cmd_is_uc_wr = (cmd_type == e_mem_msg_uc_wr);
  assign cmd_size_c   = clamp_size(cmd_size);
  assign cmd_off      = align_offset(cmd_addr[offset_width_lp-1:0], cmd_size_c);
  assign mem_index    = cmd_addr[offset_width_lp +: index_width_lp];
  assign mem_wmask    = cmd_is_wr ? '1 : (size_mask(cmd_size_c) << cmd_off);
  assign mem_wdata    = cmd_is_wr ? cmd_data : (cmd_data << {cmd_off, 3'b000});

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (mem_els_p),
    .data_width_p (block_width_p)
  ) storage (
    .clk_i        (clk_i),
    .v_i          (accept),
    .w_i          (cmd_is_wr | cmd_is_uc_wr),
    .addr_i       (mem_index),
    .data_i       (mem_wdata),
    .write_mask_i (mem_wmask),
    .data_o       (mem_rdata)
  );

  // Stage p0: accept, header capture, storage access issued
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      cnt_r      <= '0;
      hdr_r      <= '0;
      ready_en_r <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      ready_en_r <= 1'b1;
      vld_p0     <= accept;
      if (accept) begin
        hdr_r <= '{payload:  hdr_field_max_gp'(cmd_payload),
                   size:     cmd_size,
                   addr:     hdr_field_max_gp'(cmd_addr),
                   msg_type: cmd_type};
      end
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      e_idle: if (accept) begin
        state_n = e_wait;
        cnt_n   = 8'(latency_p);
      end
      e_wait: begin
        cnt_n = cnt_r - 8'd1;
        if (cnt_r <= 8'd1) state_n = e_resp;
      end
      e_resp: if (mem_resp_yumi_i) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  assign mem_cmd_ready_o = (state_r == e_idle) & ready_en_r;
  assign mem_resp_v_o    = (state_r == e_resp);

  // Stage p1: shape read data by message type and hold it for the response
  logic [offset_width_lp-1:0] hdr_off;
  logic [2:0]                 hdr_size_c;
  logic [block_width_p-1:0]   resp_data_p0;
  logic [block_width_p-1:0]   resp_data_p1;

  assign hdr_off    = hdr_r.addr[offset_width_lp-1:0];
  assign hdr_size_c = clamp_size(hdr_r.size);

  always_comb begin
    resp_data_p0 = '0;
    if (hdr_r.msg_type == e_mem_msg_rd) begin
      resp_data_p0 = mem_rdata;
    end else if (hdr_r.msg_type == e_mem_msg_uc_rd) begin
      resp_data_p0 = uc_extract(mem_rdata, align_offset(hdr_off, hdr_size_c), hdr_size_c);
    end else if (hdr_r.msg_type > e_mem_msg_uc_wr) begin
      resp_data_p0 = uc_extract(mem_rdata, hdr_off, 3'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (vld_p0) resp_data_p1 <= resp_data_p0;
  end

  assign mem_resp_o = {resp_data_p1,
                       hdr_r.payload[payload_width_p-1:0],
                       hdr_r.size,
                       hdr_r.addr[paddr_width_p-1:0],
                       hdr_r.msg_type};

  logic unused_hdr_hi;
  assign unused_hdr_hi = ^{hdr_r.addr[hdr_field_max_gp-1:paddr_width_p],
                           hdr_r.payload[hdr_field_max_gp-1:payload_width_p]};

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder at default parameters (latency 4).
module tb_mem_cmd_responder;

  localparam int AW = 40;
  localparam int BW = 512;
  localparam int PW = 16;
  localparam int MW = 4 + AW + 3 + PW + BW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [MW-1:0] mem_resp_o;
  logic          mem_resp_v_o;
  logic          mem_resp_yumi_i;

  always #5 clk = ~clk;

  mem_cmd_responder dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i)
  );

  typedef struct {
    logic [3:0]    t;
    logic [AW-1:0] addr;
    logic [2:0]    sz;
    logic [PW-1:0] pl;
    logic [BW-1:0] data;
    logic [BW-1:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack(input vec_t v);
    return {v.data, v.pl, v.sz, v.addr, v.t};
  endfunction

  task automatic issue(input vec_t v, output int lat);
    int guard;
    guard = 0;
    while (!mem_cmd_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready before cmd", BW'(mem_cmd_ready_o), BW'(1));
    mem_cmd_i   = pack(v);
    mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    lat = 0;
    while (!mem_resp_v_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    issue(v, lat);
    chk($sformatf("%s latency", tag), BW'(lat), BW'(4));
    chk($sformatf("%s data", tag), mem_resp_o[MW-1 -: BW], v.exp);
    chk($sformatf("%s header", tag), BW'(mem_resp_o[MW-BW-1:0]), BW'({v.pl, v.sz, v.addr, v.t}));
    mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_yumi_i = 1'b0;
    chk($sformatf("%s ready/v after yumi", tag), BW'({mem_cmd_ready_o, mem_resp_v_o}), BW'(2'b10));
  endtask

  logic [BW-1:0] p_blk, p2_blk, q_blk, q1_blk, j_dat, k_dat;
  vec_t          vecs[17];

  initial begin
    vec_t          hv;
    int            lat, bad, c, last_acc, last_yum, n_yum;
    logic          acc, yum;
    logic [MW-1:0] snap;

    reset_i         = 1'b1;
    mem_cmd_i       = '0;
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b0;

    for (int i = 0; i < 64; i++) begin
      p_blk[i*8 +: 8] = 8'(i);
      q_blk[i*8 +: 8] = 8'(8'hFF - i);
      j_dat[i*8 +: 8] = 8'h55;
      k_dat[i*8 +: 8] = 8'h77;
    end
    p2_blk         = p_blk;
    p2_blk[32 +: 32] = 32'hDEADBEEF;
    q1_blk         = q_blk;
    q1_blk[8 +: 8] = 8'hAA;
    j_dat[31:0]    = 32'hDEADBEEF;
    k_dat[7:0]     = 8'hAA;

    vecs[0]  = '{4'd1, 40'h80,    3'd6, 16'h1000, p_blk, '0};
    vecs[1]  = '{4'd0, 40'h80,    3'd6, 16'h1001, '0, p_blk};
    vecs[2]  = '{4'd0, 40'hBF,    3'd6, 16'h1002, '0, p_blk};
    vecs[3]  = '{4'd3, 40'h86,    3'd2, 16'h1003, j_dat, '0};
    vecs[4]  = '{4'd0, 40'h80,    3'd6, 16'h1004, '0, p2_blk};
    vecs[5]  = '{4'd2, 40'h84,    3'd2, 16'h1005, '0, BW'(32'hDEADBEEF)};
    vecs[6]  = '{4'd2, 40'h85,    3'd0, 16'h1006, '0, BW'(8'hBE)};
    vecs[7]  = '{4'd2, 40'h80,    3'd3, 16'h1007, '0, BW'(64'hDEADBEEF03020100)};
    vecs[8]  = '{4'd2, 40'h83,    3'd1, 16'h1008, '0, BW'(16'h0302)};
    vecs[9]  = '{4'd1, 40'h10000, 3'd6, 16'h1009, q_blk, '0};
    vecs[10] = '{4'd0, 40'h0,     3'd6, 16'h100A, '0, q_blk};
    vecs[11] = '{4'd9, 40'h87,    3'd5, 16'h100B, '0, BW'(8'hDE)};
    vecs[12] = '{4'd3, 40'h40,    3'd6, 16'h100C, q_blk, '0};
    vecs[13] = '{4'd0, 40'h40,    3'd6, 16'h100D, '0, q_blk};
    vecs[14] = '{4'd3, 40'h01,    3'd0, 16'h100E, k_dat, '0};
    vecs[15] = '{4'd0, 40'h00,    3'd6, 16'h100F, '0, q1_blk};
    vecs[16] = '{4'd2, 40'h01,    3'd0, 16'h1010, '0, BW'(8'hAA)};

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    chk("in reset ready/v", BW'({mem_cmd_ready_o, mem_resp_v_o}), BW'(2'b00));
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("ready after reset release", BW'(mem_cmd_ready_o), BW'(1));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Yumi withheld for 10 cycles
    hv = '{4'd0, 40'h40, 3'd6, 16'h2000, '0, q_blk};
    issue(hv, lat);
    chk("hold latency", BW'(lat), BW'(4));
    snap = mem_resp_o;
    bad  = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_resp_o !== snap || mem_resp_v_o !== 1'b1 || mem_cmd_ready_o !== 1'b0) bad++;
    end
    chk("hold stable cycles bad", BW'(bad), BW'(0));
    chk("hold data", mem_resp_o[MW-1 -: BW], q_blk);
    mem_resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_yumi_i = 1'b0;
    chk("hold ready/v after yumi", BW'({mem_cmd_ready_o, mem_resp_v_o}), BW'(2'b10));

    // Reset pulsed while a read is waiting
    hv = '{4'd0, 40'h80, 3'd6, 16'h3000, '0, p2_blk};
    mem_cmd_i   = pack(hv);
    mem_cmd_v_i = 1'b1;
    @(posedge clk); #1;
    mem_cmd_v_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    chk("mid reset ready/v", BW'({mem_cmd_ready_o, mem_resp_v_o}), BW'(2'b00));
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("ready one edge after mid reset", BW'(mem_cmd_ready_o), BW'(1));
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_resp_v_o !== 1'b0) bad++;
    end
    chk("stale resp after reset", BW'(bad), BW'(0));
    run_vec(hv, "post-reset rd");

    // Back-to-back commands with yumi held high
    hv = '{4'd0, 40'h80, 3'd6, 16'hABCD, '0, p2_blk};
    mem_cmd_i       = pack(hv);
    mem_cmd_v_i     = 1'b1;
    mem_resp_yumi_i = 1'b1;
    c = 0; last_acc = -100; last_yum = -1; n_yum = 0;
    while (n_yum < 3 && c < 100) begin
      @(negedge clk);
      acc = mem_cmd_v_i & mem_cmd_ready_o;
      yum = mem_resp_v_o & mem_resp_yumi_i;
      if (yum) begin
        chk("b2b payload", BW'(mem_resp_o[MW-BW-1 -: PW]), BW'(16'hABCD));
        chk("b2b data", mem_resp_o[MW-1 -: BW], p2_blk);
      end
      @(posedge clk);
      c++;
      if (acc) begin
        if (last_yum >= 0) chk("b2b accept after yumi gap", BW'(c - last_yum), BW'(1));
        last_acc = c;
      end
      if (yum) begin
        chk("b2b accept-to-yumi cycles", BW'(c - last_acc), BW'(5));
        last_yum = c;
        n_yum++;
      end
    end
    #1;
    mem_cmd_v_i     = 1'b0;
    mem_resp_yumi_i = 1'b0;
    chk("b2b responses seen", BW'(n_yum), BW'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
